// File: rtl/multi_blinker.sv
// Multi-channel blinker: per-channel OFF / ON / BLINK / BURST driven by a valid/ready config port.
// Define MULTI_BLINKER_BURST_EN to build BURST mode (remaining counters, busy, done); otherwise mode 11 is BLINK.
module multi_blinker_ch #(
  parameter int CNT_W = 16
`ifdef MULTI_BLINKER_BURST_EN
  , parameter int BURST_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sel,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_period,
`ifdef MULTI_BLINKER_BURST_EN
  input  logic [BURST_W-1:0] i_count,
`endif
  output logic             o_q,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_t;

  mode_t            r_mode;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q;
  logic             r_done;
`ifdef MULTI_BLINKER_BURST_EN
  logic [BURST_W-1:0] r_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= M_OFF;
      r_per  <= '0;
      r_cnt  <= '0;
      r_q    <= 1'b0;
      r_done <= 1'b0;
`ifdef MULTI_BLINKER_BURST_EN
      r_rem  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_sel) begin
        // A new beat always wins, which also aborts a running burst silently.
        r_per <= i_period;
        r_cnt <= '0;
        case (i_mode)
          2'b00: begin r_mode <= M_OFF; r_q <= 1'b0; end
          2'b01: begin r_mode <= M_ON;  r_q <= 1'b1; end
`ifdef MULTI_BLINKER_BURST_EN
          2'b11: begin
            if (i_count == '0) begin r_mode <= M_OFF;   r_q <= 1'b0; end
            else               begin r_mode <= M_BURST; r_q <= 1'b1; end
            r_rem <= i_count;
          end
`endif
          default: begin r_mode <= M_BLINK; r_q <= 1'b0; end
        endcase
      end else if (r_mode == M_BLINK || r_mode == M_BURST) begin
        if (r_cnt != r_per) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
`ifdef MULTI_BLINKER_BURST_EN
          if (r_mode == M_BURST) begin
            // End of the last low phase parks the channel instead of toggling high.
            if (r_q) begin
              r_q   <= 1'b0;
              r_rem <= r_rem - 1'b1;
            end else if (r_rem == '0) begin
              r_mode <= M_OFF;
              r_done <= 1'b1;
            end else begin
              r_q <= 1'b1;
            end
          end else begin
            r_q <= ~r_q;
          end
`else
          r_q <= ~r_q;
`endif
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_q = r_q;
`ifdef MULTI_BLINKER_BURST_EN
  assign o_busy = (r_mode == M_BURST);
  assign o_done = r_done;
`else
  assign o_busy = 1'b0;
  assign o_done = 1'b0;
  logic w_unused_done;
  assign w_unused_done = r_done;
`endif
endmodule

module multi_blinker #(
  parameter int CH      = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                         cfg_mode,
  input  logic [CNT_W-1:0]                   cfg_period,
  input  logic [BURST_W-1:0]                 cfg_count,
  output logic [CH-1:0]                      q_out,
  output logic [CH-1:0]                      busy,
  output logic [CH-1:0]                      done
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready <= 1'b0;
    else        r_ready <= 1'b1;
  end
  assign cfg_ready = r_ready;

`ifndef MULTI_BLINKER_BURST_EN
  logic [BURST_W-1:0] w_unused_count;
  assign w_unused_count = cfg_count;
`endif

  // Out-of-range cfg_ch matches no lane, so that beat is consumed with no effect.
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic w_sel;
    assign w_sel = cfg_valid && r_ready && (cfg_ch == CH_W'(g));
    multi_blinker_ch #(
      .CNT_W   (CNT_W)
`ifdef MULTI_BLINKER_BURST_EN
      , .BURST_W (BURST_W)
`endif
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sel    (w_sel),
      .i_mode   (cfg_mode),
      .i_period (cfg_period),
`ifdef MULTI_BLINKER_BURST_EN
      .i_count  (cfg_count),
`endif
      .o_q      (q_out[g]),
      .o_busy   (busy[g]),
      .o_done   (done[g])
    );
  end
endmodule

// File: tb/tb_multi_blinker.sv
// Bench for multi_blinker: per-cycle check against an arithmetic timeline model plus literal waveform checks.
// Expectations follow MULTI_BLINKER_BURST_EN the same way the design does.
module tb_multi_blinker;
  localparam int CH = 5, CNT_W = 16, BURST_W = 4, CH_W = 3;
`ifdef MULTI_BLINKER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1, cfg_valid = 1'b0, chk_en = 1'b0;
  logic cfg_ready;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [1:0]         cfg_mode = '0;
  logic [CNT_W-1:0]   cfg_period = '0;
  logic [BURST_W-1:0] cfg_count = '0;
  logic [CH-1:0] q_out, busy, done;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  multi_blinker #(.CH(CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_count(cfg_count),
    .q_out(q_out), .busy(busy), .done(done)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: per channel, the effective mode and the edge index it was accepted at.
  int m_mode[CH], m_p[CH], m_n[CH], m_t0[CH];
  bit m_rdy;
  int ecnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_mode[i] <= 0; m_p[i] <= 0; m_n[i] <= 0; m_t0[i] <= 0;
      end
    end else begin
      ecnt  <= ecnt + 1;
      m_rdy <= 1'b1;
      if (cfg_valid && m_rdy && int'(cfg_ch) < CH) begin
        if (cfg_mode == 2'd3 && !BURST_EN)      m_mode[int'(cfg_ch)] <= 2;
        else if (cfg_mode == 2'd3 && cfg_count == '0) m_mode[int'(cfg_ch)] <= 0;
        else                                    m_mode[int'(cfg_ch)] <= int'(cfg_mode);
        m_p[int'(cfg_ch)]  <= int'(cfg_period);
        m_n[int'(cfg_ch)]  <= int'(cfg_count);
        m_t0[int'(cfg_ch)] <= ecnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [CH-1:0] eq, eb, ed;
    int k, p1, len;
    if (chk_en) begin
      for (int i = 0; i < CH; i++) begin
        k = ecnt - m_t0[i]; p1 = m_p[i] + 1; len = 2 * m_n[i] * p1;
        eq[i] = 1'b0; eb[i] = 1'b0; ed[i] = 1'b0;
        case (m_mode[i])
          1: eq[i] = 1'b1;
          2: eq[i] = ((k / p1) % 2) == 1;
          3: begin
            eq[i] = (k < len) && (((k / p1) % 2) == 0);
            eb[i] = (k < len);
            ed[i] = (k == len);
          end
          default: ;
        endcase
      end
      chk("model_q_out", 32'(q_out), 32'(eq));
      chk("model_busy",  32'(busy),  32'(eb));
      chk("model_done",  32'(done),  32'(ed));
      chk("model_ready", 32'(cfg_ready), 32'(m_rdy));
    end
  end

  task automatic beat(input int ch, input int md, input int p, input int n);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_mode = 2'(md);
    cfg_period = CNT_W'(p); cfg_count = BURST_W'(n);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Samples channel ch on n consecutive negedges; first sample lands in the highest used bit.
  task automatic samp(input int ch, input int n, output logic [31:0] qv, output logic [31:0] bv,
                      output logic [31:0] dv);
    qv = '0; bv = '0; dv = '0;
    repeat (n) begin
      @(negedge clk);
      qv = {qv[30:0], q_out[ch]};
      bv = {bv[30:0], busy[ch]};
      dv = {dv[30:0], done[ch]};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] qv, bv, dv;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #20 rst_n = 1'b1;                        // t=22, edge at 25
    #2 chk("ready_before_edge", 32'(cfg_ready), 32'd0);
    #2 chk("ready_after_edge",  32'(cfg_ready), 32'd1);
    repeat (100) @(posedge clk);
    #1 chk("idle_q_out", 32'(q_out), 32'd0);

    beat(0, 2, 3, 0);
    samp(0, 16, qv, bv, dv);
    chk("blink_p3_ch0", qv, 32'b0000111100001111);

    beat(1, 2, 0, 0);
    samp(1, 8, qv, bv, dv);
    chk("blink_p0_ch1", qv, 32'b01010101);

    beat(2, 3, 1, 3);
    samp(2, 14, qv, bv, dv);
    if (BURST_EN) begin
      chk("burst3_q",    qv, 32'b11001100110000);
      chk("burst3_busy", bv, 32'b11111111111100);
      chk("burst3_done", dv, 32'b00000000000010);
    end else begin
      chk("mode3_q",    qv, 32'b00110011001100);
      chk("mode3_busy", bv, 32'd0);
      chk("mode3_done", dv, 32'd0);
    end

    beat(2, 3, 1, 5);
    samp(2, 8, qv, bv, dv);
    chk("burst5_q",    qv, BURST_EN ? 32'b11001100 : 32'b00110011);
    chk("burst5_busy", bv, BURST_EN ? 32'hFF : 32'd0);
    beat(2, 1, 0, 0);
    samp(2, 4, qv, bv, dv);
    chk("abort_q",    qv, 32'b1111);
    chk("abort_busy", bv, 32'd0);
    chk("abort_done", dv, 32'd0);

    beat(3, 3, 1, 0);
    samp(3, 8, qv, bv, dv);
    chk("burst0_q",    qv, BURST_EN ? 32'd0 : 32'b00110011);
    chk("burst0_done", dv, 32'd0);

    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_ch = 3'd0; cfg_period = '0; cfg_count = '0;
    @(posedge clk); #1; cfg_ch = 3'd1; cfg_mode = 2'd0;
    @(posedge clk); #1; cfg_ch = 3'd3; cfg_mode = 2'd1;
    @(posedge clk); #1; cfg_ch = 3'd5; cfg_mode = 2'd1;
    @(posedge clk); #1; cfg_valid = 1'b0;
    @(negedge clk);
    chk("b2b_q_out", 32'(q_out), 32'b01101);

    beat(4, 3, 2, 5);
    samp(4, 4, qv, bv, dv);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q",     32'(q_out), 32'd0);
    chk("async_rst_busy",  32'(busy),  32'd0);
    chk("async_rst_done",  32'(done),  32'd0);
    chk("async_rst_ready", 32'(cfg_ready), 32'd0);
    #12 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_q", 32'(q_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
